// File: rtl/branch_pc_if.sv
// Fetch-PC redirect bus: hazard/branch inputs toward the PC unit, fetch address and status back.
interface branch_pc_if #(
  parameter int WIDTH = 64
);
  logic             stall;
  logic             br_valid;
  logic             br_is_reg;
  logic [WIDTH-1:0] br_pc;
  logic [WIDTH-1:0] br_off_sh;
  logic [WIDTH-1:0] br_reg_tgt;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             flush;
  logic             align_fault;

  modport master (
    output stall, br_valid, br_is_reg, br_pc, br_off_sh, br_reg_tgt,
    input  pc, pc_valid, flush, align_fault
  );

  modport slave (
    input  stall, br_valid, br_is_reg, br_pc, br_off_sh, br_reg_tgt,
    output pc, pc_valid, flush, align_fault
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Fetch-stage PC register with PC-relative / register branch redirect, stall hold and
// a pending-redirect slot so a branch resolved under stall is applied once the stall clears.
module branch_pc_unit #(
  parameter int                 WIDTH    = 64,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic      clk,
  input  logic      reset_n,
  branch_pc_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic             flush_reg, flush_next;
  logic             fault_reg, fault_next;

  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] tgt_aligned;
  logic             misaligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      pend_reg  <= '0;
      flush_reg <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      pend_reg  <= pend_next;
      flush_reg <= flush_next;
      fault_reg <= fault_next;
    end
  end

  // Misaligned targets are still taken, with the low two bits cleared.
  always_comb begin
    tgt         = bus.br_is_reg ? bus.br_reg_tgt : (bus.br_pc + bus.br_off_sh);
    tgt_aligned = {tgt[WIDTH-1:2], 2'b00};
    misaligned  = |tgt[1:0];
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    pend_next  = pend_reg;
    flush_next = 1'b0;
    fault_next = fault_reg;

    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end

      RUN: begin
        if (bus.br_valid) begin
          flush_next = 1'b1;
          fault_next = fault_reg | misaligned;
          if (bus.stall) begin
            pend_next  = tgt_aligned;
            state_next = HOLD;
          end else begin
            pc_next = tgt_aligned;
          end
        end else if (!bus.stall) begin
          pc_next = pc_reg + WIDTH'(4);
        end
      end

      HOLD: begin
        if (bus.br_valid) begin
          flush_next = 1'b1;
          fault_next = fault_reg | misaligned;
        end
        // Newest branch wins over the one already pending.
        if (bus.stall) begin
          if (bus.br_valid) begin
            pend_next = tgt_aligned;
          end
        end else begin
          pc_next    = bus.br_valid ? tgt_aligned : pend_reg;
          state_next = RUN;
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign bus.pc          = pc_reg;
  assign bus.pc_valid    = (state_reg != BOOT);
  assign bus.flush       = flush_reg;
  assign bus.align_fault = fault_reg;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed vector table, random run against a reference model,
// and hand sequences for wrap-around and async reset during a held redirect.
module tb_branch_pc_unit;

  localparam int W = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_pc_if #(.WIDTH(W)) bus ();
  branch_pc_if #(.WIDTH(W)) bus_w ();

  branch_pc_unit #(.WIDTH(W), .RESET_PC(64'h0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  branch_pc_unit #(.WIDTH(W), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_w)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic bv, input logic isr,
                       input logic [W-1:0] bpc, input logic [W-1:0] off,
                       input logic [W-1:0] rt);
    bus.stall      = st;
    bus.br_valid   = bv;
    bus.br_is_reg  = isr;
    bus.br_pc      = bpc;
    bus.br_off_sh  = off;
    bus.br_reg_tgt = rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Reference model: fetch address plus an optional queued redirect.
  logic         m_booted, m_have_pend, m_flush, m_fault;
  logic [W-1:0] m_pc, m_pend;

  task automatic model_reset();
    m_booted = 0; m_have_pend = 0; m_flush = 0; m_fault = 0;
    m_pc = 64'h0; m_pend = 64'h0;
  endtask

  task automatic model_step(input logic st, input logic bv, input logic isr,
                            input logic [W-1:0] bpc, input logic [W-1:0] off,
                            input logic [W-1:0] rt);
    logic [W-1:0] t;
    t = isr ? rt : bpc + off;
    if (!m_booted) begin
      m_booted = 1;
      m_flush  = 0;
    end else begin
      m_flush = bv;
      if (bv && (t % 4 != 0)) m_fault = 1;
      t = t - (t % 4);
      if (st) begin
        if (bv) begin
          m_pend = t;
          m_have_pend = 1;
        end
      end else begin
        if (bv)               m_pc = t;
        else if (m_have_pend) m_pc = m_pend;
        else                  m_pc = m_pc + 4;
        m_have_pend = 0;
      end
    end
  endtask

  typedef struct {
    logic         st, bv, isr;
    logic [W-1:0] bpc, off, rt;
    logic [W-1:0] e_pc;
    logic         e_valid, e_flush, e_fault;
  } vec_t;

  vec_t vt[16];

  initial begin
    bus_w.stall = 0; bus_w.br_valid = 0; bus_w.br_is_reg = 0;
    bus_w.br_pc = '0; bus_w.br_off_sh = '0; bus_w.br_reg_tgt = '0;

    //        st bv isr  br_pc   off                     rt        pc      v  f  a
    vt[0]  = '{1, 1, 1, 64'h0,  64'h0,                  64'h40,  64'h0,   1, 0, 0};
    vt[1]  = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h4,   1, 0, 0};
    vt[2]  = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h8,   1, 0, 0};
    vt[3]  = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'hC,   1, 0, 0};
    vt[4]  = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h10,  1, 0, 0};
    vt[5]  = '{0, 1, 0, 64'h8,  64'hFFFF_FFFF_FFFF_FFF8, 64'h0,   64'h0,   1, 1, 0};
    vt[6]  = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h4,   1, 0, 0};
    vt[7]  = '{1, 1, 1, 64'h0,  64'h0,                  64'h100, 64'h4,   1, 1, 0};
    vt[8]  = '{1, 1, 1, 64'h0,  64'h0,                  64'h100, 64'h4,   1, 1, 0};
    vt[9]  = '{1, 1, 1, 64'h0,  64'h0,                  64'h100, 64'h4,   1, 1, 0};
    vt[10] = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h100, 1, 0, 0};
    vt[11] = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h104, 1, 0, 0};
    vt[12] = '{0, 1, 1, 64'h0,  64'h0,                  64'h202, 64'h200, 1, 1, 1};
    vt[13] = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h204, 1, 0, 1};
    vt[14] = '{1, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h204, 1, 0, 1};
    vt[15] = '{0, 0, 0, 64'h0,  64'h0,                  64'h0,   64'h208, 1, 0, 1};

    // ---- directed table ----
    do_reset();
    chk("reset_pc", bus.pc, 64'h0);
    chk("reset_valid", W'(bus.pc_valid), 64'h0);
    chk("reset_flush", W'(bus.flush), 64'h0);
    chk("reset_fault", W'(bus.align_fault), 64'h0);
    chk("wrap_reset_pc", bus_w.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].st, vt[i].bv, vt[i].isr, vt[i].bpc, vt[i].off, vt[i].rt);
      tick();
      $display("[TB] vec %0d pc=%h valid=%0b flush=%0b fault=%0b", i,
               bus.pc, bus.pc_valid, bus.flush, bus.align_fault);
      chk($sformatf("vec%0d_pc", i), bus.pc, vt[i].e_pc);
      chk($sformatf("vec%0d_valid", i), W'(bus.pc_valid), W'(vt[i].e_valid));
      chk($sformatf("vec%0d_flush", i), W'(bus.flush), W'(vt[i].e_flush));
      chk($sformatf("vec%0d_fault", i), W'(bus.align_fault), W'(vt[i].e_fault));
      if (i == 0) chk("wrap_boot_pc", bus_w.pc, 64'hFFFF_FFFF_FFFF_FFFC);
      if (i == 1) begin
        chk("wrap_pc", bus_w.pc, 64'h0);
        chk("wrap_fault", W'(bus_w.align_fault), 64'h0);
      end
    end

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      logic         st, bv, isr;
      logic [W-1:0] bpc, off, rt;
      st  = ($urandom_range(0, 9) < 3);
      bv  = ($urandom_range(0, 9) < 3);
      isr = $urandom_range(0, 1) == 1;
      bpc = {$urandom, $urandom} & ~64'h3;
      off = {$urandom, $urandom} & ~64'h3;
      rt  = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 19) == 0) begin
        off = off | 64'($urandom_range(1, 3));
        rt  = rt  | 64'($urandom_range(1, 3));
      end
      drive(st, bv, isr, bpc, off, rt);
      tick();
      model_step(st, bv, isr, bpc, off, rt);
      $display("[TB] rnd %0d st=%0b bv=%0b pc=%h flush=%0b fault=%0b", n, st, bv,
               bus.pc, bus.flush, bus.align_fault);
      chk("rnd_pc", bus.pc, m_pc);
      chk("rnd_valid", W'(bus.pc_valid), W'(m_booted));
      chk("rnd_flush", W'(bus.flush), W'(m_flush));
      chk("rnd_fault", W'(bus.align_fault), W'(m_fault));
    end

    // ---- async reset while a redirect is pending ----
    drive(0, 0, 0, '0, '0, '0);
    tick();
    drive(1, 1, 1, '0, '0, 64'h300);
    tick();
    chk("hold_flush", W'(bus.flush), 64'h1);
    drive(1, 0, 0, '0, '0, '0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    $display("[TB] async reset pc=%h valid=%0b", bus.pc, bus.pc_valid);
    chk("async_pc", bus.pc, 64'h0);
    chk("async_valid", W'(bus.pc_valid), 64'h0);
    chk("async_fault", W'(bus.align_fault), 64'h0);
    drive(0, 0, 0, '0, '0, '0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] exp_pc;
      exp_pc = (k == 0) ? 64'h0 : 64'(4 * k);
      tick();
      $display("[TB] post-reset %0d pc=%h", k, bus.pc);
      chk($sformatf("post_reset%0d_pc", k), bus.pc, exp_pc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
